bit_serial_mul_seq: RTL

//   Sequencer on the far end of bit_serial_mul's serial port. Takes a parallel multiplier b via valid/ready.

---
 rtl/bsm_pkg.sv | 17 +
 rtl/bsm_shift_reg.sv | 41 ++++
 rtl/bit_serial_mul_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bsm_pkg.sv
// Shared types and constants for the bit_serial_mul sequencer.
package bsm_pkg;

  typedef enum logic [1:0] {
    BSM_IDLE,
    BSM_SHIFT,
    BSM_DONE
  } bsm_state_t;

  localparam int OPCNT_W = 32;

  // Length of one serial frame: 2W product bits plus the array's output latency.
  function automatic int bsm_frame_len(input int w, input int y_lat);
    return 2 * w + y_lat;
  endfunction

endpackage

// File: rtl/bsm_shift_reg.sv
// Right-shifting register with parallel load and LSB-first serial in/out.
// Used both as the operand PISO and the product SIPO.
module bsm_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [WIDTH-1:0] nxt_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // NOTE: the hold value is assigned first so every path writes data_d and no latch is inferred.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {ser_i, data_q[WIDTH-1:1]};
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign ser_o = data_q[0];
  assign nxt_o = data_d;

endmodule

// File: rtl/bit_serial_mul_seq.sv
// Sequencer for one bit_serial_mul: streams b LSB-first, zero-pads, collects the 2W-bit product.
// Define BSM_OPCNT_EN to add the op_count port counting completed products.
module bit_serial_mul_seq
  import bsm_pkg::*;
#(
  parameter int W     = 16,
  parameter int Y_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_b,
  output logic             x_bit,
  input  logic             y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             busy
`ifdef BSM_OPCNT_EN
  ,
  output logic [OPCNT_W-1:0] op_count
`endif
);

  localparam int N     = bsm_frame_len(W, Y_LAT);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  bsm_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [2*W-1:0]   out_p_q;

  logic             accept;
  logic             shifting;
  logic             cap_en;
  logic             b_ser;
  logic [W-1:0]     piso_nxt_unused;
  logic             sipo_ser_unused;
  logic [2*W-1:0]   sipo_nxt;

  assign accept   = in_valid & in_ready_q;
  assign shifting = (state_q == BSM_SHIFT);

  // The first Y_LAT cycles of a frame carry no product bit yet.
  if (Y_LAT == 0) begin : g_cap_always
    assign cap_en = shifting;
  end else begin : g_cap_delayed
    assign cap_en = shifting && (cnt_q >= CNT_W'(Y_LAT));
  end

  // Zeros shift in behind b, so x_bit pads with 0 once all W bits are out.
  bsm_shift_reg #(.WIDTH(W)) u_piso (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_data_i(in_b),
    .shift_i    (shifting),
    .ser_i      (1'b0),
    .ser_o      (b_ser),
    .nxt_o      (piso_nxt_unused)
  );

  bsm_shift_reg #(.WIDTH(2 * W)) u_sipo (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (1'b0),
    .load_data_i('0),
    .shift_i    (cap_en),
    .ser_i      (y),
    .ser_o      (sipo_ser_unused),
    .nxt_o      (sipo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BSM_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_p_q     <= '0;
    end else begin
      unique case (state_q)
        BSM_IDLE: begin
          if (accept) begin
            state_q    <= BSM_SHIFT;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BSM_SHIFT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Take the SIPO's next value so the final captured bit lands in out_p.
          if (cnt_q == CNT_LAST) begin
            state_q     <= BSM_DONE;
            out_valid_q <= 1'b1;
            out_p_q     <= sipo_nxt;
          end
        end
        BSM_DONE: begin
          if (out_ready) begin
            state_q     <= BSM_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= BSM_IDLE;
      endcase
    end
  end

`ifdef BSM_OPCNT_EN
  logic [OPCNT_W-1:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      op_count_q <= op_count_q + OPCNT_W'(1);
    end
  end

  assign op_count = op_count_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = busy_q;
  assign x_bit     = shifting & b_ser;

endmodule
